// File: rtl/send_arbiter_pkg.sv
// Shared definitions for the framing send-path arbiter: FSM state encoding and
// default sizing for the requester count and packet length width.
package send_arbiter_pkg;

    localparam int SEND_NREQ     = 3;
    localparam int SEND_LEN_BITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/send_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping, returned both one-hot and as an index.
module send_arbiter_rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] pos;

    // Scan from the farthest offset inward so the nearest request to ptr_i wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'((int'(ptr_i) + k) % N);
            if (req_i[pos]) begin
                grant_o      = '0;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/send_arbiter.sv
// Shares the framing send path between NREQ packet producers: one whole packet per
// grant, payload bytes into the ring first, then the length word into the fifo.
module send_arbiter
    import send_arbiter_pkg::*;
#(
    parameter int NREQ     = SEND_NREQ,
    parameter int LEN_BITS = SEND_LEN_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*LEN_BITS-1:0] req_len_i,
    input  logic [NREQ*8-1:0]        req_data_i,
    output logic [NREQ-1:0]          req_rd_en_o,
    output logic [NREQ-1:0]          req_done_o,
    output logic [7:0]               send_ring_data_o,
    output logic                     send_ring_wr_en_o,
    input  logic                     send_ring_full_i,
    output logic [LEN_BITS-1:0]      send_fifo_data_o,
    output logic                     send_fifo_wr_en_o,
    input  logic                     send_fifo_full_i,
    output logic                     busy_o
);

    localparam int IW = (NREQ <= 1) ? 1 : $clog2(NREQ);

    state_e              state_q;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       gidx_q;
    logic [NREQ-1:0]     gnt_q;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]     arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                arb_valid;
    logic                stream_pop;

    logic [7:0]          req_byte  [NREQ];
    logic [LEN_BITS-1:0] req_len_w [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign req_byte[gi]  = req_data_i[gi*8 +: 8];
        assign req_len_w[gi] = req_len_i[gi*LEN_BITS +: LEN_BITS];
    end

    send_arbiter_rr_arbiter #(.N(NREQ)) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Pop is combinational so the producer advances in the same cycle the byte is captured.
    assign stream_pop  = (state_q == ST_STREAM) && !send_ring_full_i;
    assign req_rd_en_o = gnt_q & {NREQ{stream_pop}};
    assign busy_o      = (state_q != ST_IDLE);

    assign cnt_d = cnt_q + 1'b1;
    assign ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q           <= ST_IDLE;
            ptr_q             <= '0;
            gidx_q            <= '0;
            gnt_q             <= '0;
            len_q             <= '0;
            cnt_q             <= '0;
            send_ring_data_o  <= '0;
            send_ring_wr_en_o <= 1'b0;
            send_fifo_data_o  <= '0;
            send_fifo_wr_en_o <= 1'b0;
            req_done_o        <= '0;
        end else begin
            send_ring_wr_en_o <= 1'b0;
            send_fifo_wr_en_o <= 1'b0;
            req_done_o        <= '0;
            case (state_q)
                ST_IDLE: begin
                    // No grant while the length fifo is full, so a packet can always commit.
                    if (arb_valid && !send_fifo_full_i) begin
                        gidx_q  <= arb_idx;
                        gnt_q   <= arb_grant;
                        len_q   <= req_len_w[arb_idx];
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= (len_q == '0) ? ST_COMMIT : ST_STREAM;
                end
                ST_STREAM: begin
                    if (!send_ring_full_i) begin
                        send_ring_data_o  <= req_byte[gidx_q];
                        send_ring_wr_en_o <= 1'b1;
                        cnt_q             <= cnt_d;
                        if (cnt_d == {1'b0, len_q}) begin
                            state_q <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (!send_fifo_full_i) begin
                        send_fifo_data_o  <= len_q;
                        send_fifo_wr_en_o <= 1'b1;
                        req_done_o        <= gnt_q;
                        ptr_q             <= ptr_d;
                        state_q           <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_send_arbiter.sv
// Bench for send_arbiter: producer queues, a round-robin packet-order model and
// byte scoreboard, driven through directed scenarios and a randomized run.
module tb_send_arbiter;

    localparam int NREQ = 3;
    localparam int LB   = 6;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [NREQ-1:0]     req_valid_i;
    logic [NREQ*LB-1:0]  req_len_i;
    logic [NREQ*8-1:0]   req_data_i;
    logic [NREQ-1:0]     req_rd_en_o;
    logic [NREQ-1:0]     req_done_o;
    logic [7:0]          send_ring_data_o;
    logic                send_ring_wr_en_o;
    logic                send_ring_full_i;
    logic [LB-1:0]       send_fifo_data_o;
    logic                send_fifo_wr_en_o;
    logic                send_fifo_full_i;
    logic                busy_o;

    send_arbiter #(.NREQ(NREQ), .LEN_BITS(LB)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_len_i         (req_len_i),
        .req_data_i        (req_data_i),
        .req_rd_en_o       (req_rd_en_o),
        .req_done_o        (req_done_o),
        .send_ring_data_o  (send_ring_data_o),
        .send_ring_wr_en_o (send_ring_wr_en_o),
        .send_ring_full_i  (send_ring_full_i),
        .send_fifo_data_o  (send_fifo_data_o),
        .send_fifo_wr_en_o (send_fifo_wr_en_o),
        .send_fifo_full_i  (send_fifo_full_i),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    // Producer-side model: each requester holds one packet, consumed from head_m.
    logic [7:0] pkt_mem [NREQ][64];
    int         len_m   [NREQ];
    int         head_m  [NREQ];
    bit         valid_m [NREQ];
    int         pop_cnt [NREQ];

    int         ptr_m;
    int         cur_g;
    int         wr_count;
    int         commits;
    int         fifo_writes;
    int         ring_writes;
    int         ticks;
    int         mode;
    int         refills;
    int         done_log [$];
    logic [7:0] ring_log [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int idx = (ptr_m + k) % NREQ;
            if (valid_m[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int rand_len();
        if ($urandom_range(0, 15) == 0) return 63;
        return int'($urandom_range(0, 10));
    endfunction

    task automatic load(input int i, input int len);
        for (int k = 0; k < 64; k++) pkt_mem[i][k] = 8'($urandom);
        len_m[i]   = len;
        head_m[i]  = 0;
        valid_m[i] = 1'b1;
    endtask

    // The next packet is decided only while the arbiter is between packets.
    task automatic settle();
        if (cur_g < 0) cur_g = pick();
    endtask

    task automatic on_done(input int g);
        bit any;
        if (mode == 1 && refills > 0) begin
            refills--;
            load(g, 3);
        end else if (mode == 2) begin
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!valid_m[i] && $urandom_range(0, 1) == 1) load(i, rand_len());
                if (valid_m[i]) any = 1'b1;
            end
            if (!any) load(int'($urandom_range(0, NREQ - 1)), rand_len());
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid_i[i]         = valid_m[i];
            req_len_i[i*LB +: LB]  = LB'(len_m[i]);
            req_data_i[i*8 +: 8]   = (head_m[i] < len_m[i]) ? pkt_mem[i][head_m[i]] : 8'h00;
        end
    endtask

    // One clock cycle, entered and left at a negative edge.
    task automatic tick();
        logic [NREQ-1:0] pops;
        logic [7:0]      pb;
        bit              ff;
        int              g;
        pb = 8'h00;
        drive();
        #1;
        pops = req_rd_en_o;
        ff   = send_fifo_full_i;
        if (pops != '0) begin
            chk("pop_during_full", 32'(send_ring_full_i), 32'd0);
            chk("pop_grantee", 32'(pops), (cur_g >= 0) ? (32'd1 << cur_g) : 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        ticks++;
        for (int i = 0; i < NREQ; i++) begin
            if (pops[i]) begin
                chk("pop_overrun", 32'(head_m[i] < len_m[i]), 32'd1);
                if (head_m[i] < len_m[i]) begin
                    pb = pkt_mem[i][head_m[i]];
                    head_m[i]++;
                end
                pop_cnt[i]++;
            end
        end
        chk("ring_wr", 32'(send_ring_wr_en_o), 32'(pops != '0));
        if (send_ring_wr_en_o) begin
            ring_writes++;
            wr_count++;
            ring_log.push_back(send_ring_data_o);
            if (pops != '0) chk("ring_byte", 32'(send_ring_data_o), 32'(pb));
        end
        if (send_fifo_wr_en_o || req_done_o != '0) begin
            fifo_writes++;
            commits++;
            g = cur_g;
            chk("fifo_wr", 32'(send_fifo_wr_en_o), 32'd1);
            chk("done_vec", 32'(req_done_o), (g >= 0) ? (32'd1 << g) : 32'd0);
            chk("commit_while_full", 32'(ff), 32'd0);
            if (g >= 0) begin
                chk("fifo_len", 32'(send_fifo_data_o), 32'(len_m[g]));
                chk("byte_count", 32'(wr_count), 32'(len_m[g]));
                done_log.push_back(g);
                valid_m[g] = 1'b0;
                ptr_m = (g + 1) % NREQ;
            end
            wr_count = 0;
            cur_g    = -1;
            on_done(g);
            settle();
        end
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (commits < target && n < budget) begin
            tick();
            n++;
        end
        chk("timeout", 32'(commits >= target), 32'd1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            valid_m[i] = 1'b0;
            len_m[i]   = 0;
            head_m[i]  = 0;
        end
        ptr_m    = 0;
        cur_g    = -1;
        wr_count = 0;
    endtask

    initial begin
        int t0, rl, fw, pc, rw, ds, c0, n;
        rst_i            = 1'b1;
        send_ring_full_i = 1'b0;
        send_fifo_full_i = 1'b0;
        mode = 0; refills = 0; commits = 0; fifo_writes = 0; ring_writes = 0; ticks = 0;
        for (int i = 0; i < NREQ; i++) pop_cnt[i] = 0;
        model_reset();
        drive();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ring_wr", 32'(send_ring_wr_en_o), 32'd0);
        chk("rst_ring_data", 32'(send_ring_data_o), 32'd0);
        chk("rst_fifo_wr", 32'(send_fifo_wr_en_o), 32'd0);
        chk("rst_fifo_data", 32'(send_fifo_data_o), 32'd0);
        chk("rst_done", 32'(req_done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;

        // req0 and req2 together from ptr 0, refilled: order alternates 0,2,0,2
        mode = 1; refills = 2;
        ds = done_log.size();
        load(0, 3); load(2, 3); settle();
        run_until(commits + 4, 200);
        mode = 0;
        if (done_log.size() >= ds + 4) begin
            chk("rr_order0", 32'(done_log[ds]),     32'd0);
            chk("rr_order1", 32'(done_log[ds + 1]), 32'd2);
            chk("rr_order2", 32'(done_log[ds + 2]), 32'd0);
            chk("rr_order3", 32'(done_log[ds + 3]), 32'd2);
        end

        // Single req0, bytes 11 22 33 44, latency len+3
        load(0, 4);
        pkt_mem[0][0] = 8'h11; pkt_mem[0][1] = 8'h22; pkt_mem[0][2] = 8'h33; pkt_mem[0][3] = 8'h44;
        settle();
        rl = ring_log.size(); pc = pop_cnt[0]; t0 = ticks;
        run_until(commits + 1, 50);
        chk("latency4", 32'(ticks - t0), 32'd7);
        chk("pops4", 32'(pop_cnt[0] - pc), 32'd4);
        if (ring_log.size() >= rl + 4) begin
            chk("byte11", 32'(ring_log[rl]),     32'h11);
            chk("byte22", 32'(ring_log[rl + 1]), 32'h22);
            chk("byte33", 32'(ring_log[rl + 2]), 32'h33);
            chk("byte44", 32'(ring_log[rl + 3]), 32'h44);
        end
        chk("done_req0", 32'(done_log[$]), 32'd0);

        // req1 len 6 with ring full for three cycles mid-packet
        load(1, 6); settle();
        rw = ring_writes; fw = fifo_writes; pc = pop_cnt[1]; t0 = ticks; n = 0;
        while (commits < fw + 0 + (commits - fw) + 1 && n < 60 && fifo_writes == fw) begin
            send_ring_full_i = ((ticks - t0) >= 4 && (ticks - t0) < 7);
            tick();
            n++;
        end
        send_ring_full_i = 1'b0;
        chk("stall_timeout", 32'(fifo_writes - fw), 32'd1);
        chk("stall_latency", 32'(ticks - t0), 32'd12);
        chk("stall_bytes", 32'(ring_writes - rw), 32'd6);
        chk("stall_pops", 32'(pop_cnt[1] - pc), 32'd6);

        // Zero-length packet on req1: length word only
        load(1, 0); settle();
        rw = ring_writes; t0 = ticks;
        run_until(commits + 1, 20);
        chk("zero_latency", 32'(ticks - t0), 32'd3);
        chk("zero_no_bytes", 32'(ring_writes - rw), 32'd0);
        chk("zero_done_req1", 32'(done_log[$]), 32'd1);

        // Length fifo full for five cycles while in COMMIT
        load(2, 2); settle();
        fw = fifo_writes; t0 = ticks; n = 0;
        while (fifo_writes == fw && n < 40) begin
            send_fifo_full_i = ((ticks - t0) >= 4 && (ticks - t0) < 9);
            tick();
            n++;
        end
        send_fifo_full_i = 1'b0;
        chk("commit_hold_latency", 32'(ticks - t0), 32'd10);
        repeat (3) tick();
        chk("commit_once", 32'(fifo_writes - fw), 32'd1);

        // Fifo full in IDLE: no grant, no pops
        send_fifo_full_i = 1'b1;
        load(0, 2); settle();
        pc = pop_cnt[0]; c0 = commits;
        repeat (6) tick();
        chk("idle_full_pops", 32'(pop_cnt[0] - pc), 32'd0);
        chk("idle_full_busy", 32'(busy_o), 32'd0);
        chk("idle_full_commits", 32'(commits - c0), 32'd0);
        send_fifo_full_i = 1'b0;
        run_until(commits + 1, 30);

        // Reset during STREAM, then fresh arbitration from req0
        load(0, 10); settle();
        repeat (4) tick();
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        drive();
        rst_i = 1'b1;
        #1;
        chk("arst_ring_wr", 32'(send_ring_wr_en_o), 32'd0);
        chk("arst_ring_data", 32'(send_ring_data_o), 32'd0);
        chk("arst_rd_en", 32'(req_rd_en_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        ds = done_log.size();
        load(0, 3); load(2, 3); settle();
        run_until(commits + 2, 60);
        if (done_log.size() >= ds + 2) begin
            chk("post_rst_first", 32'(done_log[ds]),     32'd0);
            chk("post_rst_second", 32'(done_log[ds + 1]), 32'd2);
        end

        // Randomized traffic with random back-pressure on both outputs
        mode = 2;
        c0 = commits;
        if (cur_g < 0) load(int'($urandom_range(0, NREQ - 1)), rand_len());
        settle();
        for (int k = 0; k < 2000; k++) begin
            send_ring_full_i = ($urandom_range(0, 3) == 0);
            send_fifo_full_i = ($urandom_range(0, 4) == 0);
            tick();
        end
        mode = 0;
        send_ring_full_i = 1'b0;
        send_fifo_full_i = 1'b0;
        n = 0;
        while (cur_g >= 0 && n < 600) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(cur_g), 32'hffff_ffff);
        chk("drain_busy", 32'(busy_o), 32'd0);
        chk("random_progress", 32'((commits - c0) > 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
